// File: rtl/aes_key_sched_ctrl_if.sv
// Bundle of the AES-128 key-schedule controller signals.
//   ld, kld, wk, rnd        : expansion start / datapath sequencing
//   busy, done, keys_vld    : status
//   rd_en, rd_idx, rd_key,
//   rd_vld                  : random-access round-key read port
// slave  : the controller side
// master : the side that starts expansions, supplies wk and reads keys
interface aes_key_sched_ctrl_if;
   logic         ld;
   logic         kld;
   logic [127:0] wk;
   logic [3:0]   rnd;
   logic         busy;
   logic         done;
   logic         keys_vld;
   logic         rd_en;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic         rd_vld;

   modport slave (
      input  ld, wk, rd_en, rd_idx,
      output kld, rnd, busy, done, keys_vld, rd_key, rd_vld
   );

   modport master (
      output ld, wk, rd_en, rd_idx,
      input  kld, rnd, busy, done, keys_vld, rd_key, rd_vld
   );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencing controller.
// Issues a one-cycle kld to the rcon generator / expansion datapath, tracks
// the round index, captures rk0..rk10 into a key cache and serves them back
// through a 1-cycle-latency random-access read port.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : aes_key_sched_ctrl_if.slave (ld, kld, wk, rnd, busy, done,
//          keys_vld, rd_en, rd_idx, rd_key, rd_vld)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for ld
// LOAD  | kld high for one cycle, keys_vld cleared, cnt = 0
// EXP   | cache[cnt] <= wk each cycle, cnt 0..10
// DONE  | done pulse; ld here restarts directly into LOAD
module aes_key_sched_ctrl (
   input  logic                clk,
   input  logic                rst,
   aes_key_sched_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, EXP, DONE} state_t;

   localparam logic [3:0] LAST_RND = 4'd10;

   state_t       state;
   logic [3:0]   cnt;
   logic         kld_q;
   logic         busy_q;
   logic         done_q;
   logic         keys_vld_q;
   logic [127:0] rd_key_q;
   logic         rd_vld_q;
   logic [127:0] cache [11];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         kld_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         keys_vld_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ld) begin
                  state      <= LOAD;
                  cnt        <= 4'd0;
                  kld_q      <= 1'b1;
                  busy_q     <= 1'b1;
                  keys_vld_q <= 1'b0;
               end
            end
            LOAD: begin
               state <= EXP;
               kld_q <= 1'b0;
            end
            EXP: begin
               // cnt stops at 10 and is held there, so rnd keeps showing 10
               // until the next LOAD.
               if (cnt == LAST_RND) begin
                  state      <= DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  keys_vld_q <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               if (bus.ld) begin
                  state      <= LOAD;
                  cnt        <= 4'd0;
                  kld_q      <= 1'b1;
                  busy_q     <= 1'b1;
                  keys_vld_q <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Cache is deliberately not reset; keys_vld gates every read.
   always_ff @(posedge clk) begin
      if (state == EXP) begin
         cache[cnt] <= bus.wk;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_key_q <= '0;
         rd_vld_q <= 1'b0;
      end else if (bus.rd_en && keys_vld_q && (bus.rd_idx <= LAST_RND)) begin
         rd_key_q <= cache[bus.rd_idx];
         rd_vld_q <= 1'b1;
      end else begin
         rd_key_q <= '0;
         rd_vld_q <= 1'b0;
      end
   end

   assign bus.kld      = kld_q;
   assign bus.rnd      = cnt;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.keys_vld = keys_vld_q;
   assign bus.rd_key   = rd_key_q;
   assign bus.rd_vld   = rd_vld_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

   logic clk;
   logic rst;
   logic key_sel;
   logic [3:0] dp_idx;
   int checks;
   int errors;

   aes_key_sched_ctrl_if bus ();

   aes_key_sched_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIPS-197 Appendix A round keys for 2b7e151628aed2a6abf7158809cf4f3c.
   // Set 1 is a second, distinct key set (set 0 xor a fixed pattern).
   function automatic logic [127:0] rk(input logic sel, input int i);
      logic [127:0] k;
      case (i)
         0:       k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
         1:       k = 128'ha0fafe1788542cb123a339392a6c7605;
         2:       k = 128'hf2c295f27a96b9435935807a7359f67f;
         3:       k = 128'h3d80477d4716fe3e1e237e446d7a883b;
         4:       k = 128'hef44a541a8525b7fb671253bdb0bad00;
         5:       k = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
         6:       k = 128'h6d88a37a110b3efddbf98641ca0093fd;
         7:       k = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
         8:       k = 128'head27321b58dbad2312bf5607f8d292f;
         9:       k = 128'hac7766f319fadc2128d12941575c006e;
         default: k = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      endcase
      if (sel) k = k ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
      return k;
   endfunction

   // Datapath model: rk0 appears the cycle after kld is sampled, then one
   // new key per cycle, holding rk10.
   always @(posedge clk or negedge rst) begin
      if (!rst)                 dp_idx <= 4'd10;
      else if (bus.kld)         dp_idx <= 4'd0;
      else if (dp_idx != 4'd10) dp_idx <= dp_idx + 4'd1;
   end

   assign bus.wk = rk(key_sel, int'(dp_idx));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full expansion. Without pre_started, ld is raised in cycle t.
   // Loop index k is the cycle offset from t.
   task automatic expand(input logic sel, input logic ld_busy, input logic chain,
                         input logic pre_started);
      logic [3:0] exp_rnd;
      if (!pre_started) begin
         key_sel = sel;
         bus.ld  = 1'b1;
         bus.rd_en = 1'b0;
         tick();
      end
      for (int k = 1; k <= 13; k++) begin
         bus.ld = ((ld_busy && (k == 4 || k == 9)) || (chain && k == 13)) ? 1'b1 : 1'b0;
         if (chain && k == 13) key_sel = ~sel;
         bus.rd_en  = (chain && k == 13) ? 1'b0 : 1'b1;
         bus.rd_idx = (k == 13) ? 4'd10 : 4'(k % 11);
         exp_rnd = (k == 1) ? 4'd0 : ((k <= 12) ? 4'(k - 2) : 4'd10);
         chk($sformatf("s%0d k=%0d kld", sel, k), 128'(bus.kld), 128'(k == 1));
         chk($sformatf("s%0d k=%0d busy", sel, k), 128'(bus.busy), 128'(k <= 12));
         chk($sformatf("s%0d k=%0d done", sel, k), 128'(bus.done), 128'(k == 13));
         chk($sformatf("s%0d k=%0d keys_vld", sel, k), 128'(bus.keys_vld), 128'(k == 13));
         chk($sformatf("s%0d k=%0d rnd", sel, k), 128'(bus.rnd), 128'(exp_rnd));
         chk($sformatf("s%0d k=%0d rd_vld", sel, k), 128'(bus.rd_vld), 128'(0));
         chk($sformatf("s%0d k=%0d rd_key", sel, k), bus.rd_key, 128'(0));
         tick();
      end
      bus.ld = 1'b0;
      bus.rd_en = 1'b0;
      chk($sformatf("s%0d post kld", sel), 128'(bus.kld), 128'(chain));
      chk($sformatf("s%0d post keys_vld", sel), 128'(bus.keys_vld), 128'(!chain));
      chk($sformatf("s%0d post done", sel), 128'(bus.done), 128'(0));
      chk($sformatf("s%0d post rd_vld", sel), 128'(bus.rd_vld), 128'(!chain));
      chk($sformatf("s%0d post rd_key", sel), bus.rd_key, chain ? 128'(0) : rk(sel, 10));
      if (!chain) begin
         for (int i = 10; i >= 0; i--) begin
            bus.rd_en  = 1'b1;
            bus.rd_idx = 4'(i);
            tick();
            chk($sformatf("s%0d sweep %0d vld", sel, i), 128'(bus.rd_vld), 128'(1));
            chk($sformatf("s%0d sweep %0d key", sel, i), bus.rd_key, rk(sel, i));
         end
         bus.rd_en = 1'b0;
         tick();
         chk($sformatf("s%0d idle rd_vld", sel), 128'(bus.rd_vld), 128'(0));
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      key_sel    = 1'b0;
      bus.ld     = 1'b0;
      bus.rd_en  = 1'b0;
      bus.rd_idx = 4'd0;

      repeat (3) tick();
      chk("rst kld", 128'(bus.kld), 128'(0));
      chk("rst busy", 128'(bus.busy), 128'(0));
      chk("rst done", 128'(bus.done), 128'(0));
      chk("rst keys_vld", 128'(bus.keys_vld), 128'(0));
      chk("rst rnd", 128'(bus.rnd), 128'(0));
      chk("rst rd_key", bus.rd_key, 128'(0));
      chk("rst rd_vld", 128'(bus.rd_vld), 128'(0));
      rst = 1'b1;
      tick();

      // Read before any key set exists.
      bus.rd_en  = 1'b1;
      bus.rd_idx = 4'd0;
      tick();
      chk("pre rd_vld", 128'(bus.rd_vld), 128'(0));
      bus.rd_en = 1'b0;
      tick();

      // FIPS-197 expansion with DONE-cycle read and reverse sweep.
      expand(1'b0, 1'b0, 1'b0, 1'b0);

      // Out-of-range and disabled reads with keys_vld set.
      bus.rd_en  = 1'b1;
      bus.rd_idx = 4'd11;
      tick();
      chk("idx11 vld", 128'(bus.rd_vld), 128'(0));
      chk("idx11 key", bus.rd_key, 128'(0));
      bus.rd_idx = 4'd15;
      tick();
      chk("idx15 vld", 128'(bus.rd_vld), 128'(0));
      chk("idx15 key", bus.rd_key, 128'(0));
      bus.rd_en  = 1'b0;
      bus.rd_idx = 4'd5;
      tick();
      chk("rd_en0 vld", 128'(bus.rd_vld), 128'(0));
      chk("keys_vld held", 128'(bus.keys_vld), 128'(1));
      chk("rnd held", 128'(bus.rnd), 128'(10));

      // ld pulses while busy are ignored.
      expand(1'b1, 1'b1, 1'b0, 1'b0);

      // Back-to-back: second ld in the DONE cycle, new key set.
      expand(1'b0, 1'b0, 1'b1, 1'b0);
      expand(1'b1, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of EXP (cnt = 5).
      key_sel = 1'b0;
      bus.ld  = 1'b1;
      tick();
      bus.ld = 1'b0;
      repeat (6) tick();
      chk("mid rnd", 128'(bus.rnd), 128'(5));
      chk("mid busy", 128'(bus.busy), 128'(1));
      #2 rst = 1'b0;
      #1;
      chk("abort kld", 128'(bus.kld), 128'(0));
      chk("abort busy", 128'(bus.busy), 128'(0));
      chk("abort done", 128'(bus.done), 128'(0));
      chk("abort keys_vld", 128'(bus.keys_vld), 128'(0));
      chk("abort rnd", 128'(bus.rnd), 128'(0));
      chk("abort rd_key", bus.rd_key, 128'(0));
      chk("abort rd_vld", 128'(bus.rd_vld), 128'(0));
      #2 rst = 1'b1;
      bus.rd_en  = 1'b1;
      bus.rd_idx = 4'd0;
      tick();
      chk("abort read vld", 128'(bus.rd_vld), 128'(0));
      chk("abort read key", bus.rd_key, 128'(0));
      chk("abort idle busy", 128'(bus.busy), 128'(0));
      bus.rd_en = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencing controller for the AES-128 key-expansion path. It issues the single-cycle `kld` that resets the round-constant generator and key-expansion datapath, then tracks the round index. It captures the 11 round keys (rk0..rk10) emitted on consecutive cycles into an internal key cache. A random-access read port lets the inverse cipher consume round keys in any order, typically rk10 down to rk0.

## Interface
Parameters:
- none (AES-128 only; 11 round keys, 128-bit words)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ld  in  1  start-expansion request, sampled on clk
- kld  out  1  load strobe to the rcon generator and key-expansion datapath
- wk  in  128  current round key from the key-expansion datapath, {w0,w1,w2,w3}
- rnd  out  4  index of the round key currently presented on wk
- busy  out  1  expansion in progress (LOAD or EXP)
- done  out  1  one-cycle pulse when rk10 has been captured
- keys_vld  out  1  cache holds a complete, consistent key set
- rd_en  in  1  cache read request
- rd_idx  in  4  round-key index to read, 0..10
- rd_key  out  128  read data
- rd_vld  out  1  rd_key valid qualifier

## Operation
FSM states are IDLE, LOAD, EXP and DONE.
- **IDLE:** `kld`=0. An `ld`=1 moves the FSM to LOAD.
- **LOAD:** `kld`=1 for exactly this one cycle (Moore output). `keys_vld` is cleared on entry. `cnt` is set to 0. The FSM then moves to EXP.
- **EXP:**
  - Each cycle, wk is written to cache[cnt], `rnd`=cnt, and `cnt` increments.
  - When `cnt`==10 the write completes, `keys_vld` is set, and the FSM moves to DONE.
- **DONE:** `done`=1 for one cycle, then the FSM moves to IDLE. An `ld`=1 in DONE moves directly to LOAD, and `done` still pulses that cycle.
- **ld while busy (LOAD/EXP):** ignored. No restart, and the sequence completes normally.
- **Counter:** `cnt` is 4-bit, range 0..10, and never wraps within EXP.
- **rnd:** holds its last value (10) outside EXP until the next LOAD, which sets it to 0.
- **Read port:**
  - Sampled every cycle.
  - If `rd_en`=1, `keys_vld`=1 and `rd_idx`<=10: next cycle `rd_key`=cache[rd_idx] and `rd_vld`=1.
  - Otherwise: next cycle `rd_key`=0 and `rd_vld`=0.
- **Read during LOAD/EXP:** `keys_vld`=0, so `rd_vld`=0, and no partial key set is ever returned.
- **Cache array:** not reset. Visibility is gated by `keys_vld`.

## Timing
- **Reset values:** `kld`=0, `busy`=0, `done`=0, `keys_vld`=0, `rnd`=0, `rd_key`=0, `rd_vld`=0. The FSM is in IDLE and `cnt`=0.
- **Reset during LOAD/EXP:** the sequence is aborted immediately and all outputs return to their reset values. The cache contents are unusable until the next full sequence.
- **Start latency:**
  - Cycle t: `ld` sampled.
  - Cycle t+1: LOAD, `kld`=1.
  - Cycles t+2 .. t+12: EXP, capturing rk0..rk10. This relies on the datapath presenting rk0 the cycle after `kld` is sampled and one new key per cycle.
  - Cycle t+13: DONE, `done`=1 and `keys_vld`=1.
- **busy:** high during cycles t+1 .. t+12.
- **Back-to-back restart:** `ld` held continuously gives one `kld` every 13 cycles.
- **Read latency:** 1 cycle from `rd_en` to `rd_key`/`rd_vld`. One read is accepted per cycle, pipelined.
- **Read in the DONE cycle:** returns valid data, because `keys_vld` is already set.

## Test plan
- **Reset:** assert `rst`=0 mid-EXP (`cnt`=5) -> all outputs 0, FSM IDLE, and a following `rd_en` with `rd_idx`=0 returns `rd_vld`=0.
- **FIPS-197 expansion:**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, with wk driven by the datapath model, `ld` pulsed at t.
  - Required: `kld` high only at t+1; `done` at t+13.
  - Required: `rd_idx`=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6, and `rd_idx`=0 returns the original key.
- **Reverse read sweep:** after `done`, `rd_en`=1 with `rd_idx` 10..0 on consecutive cycles -> 11 consecutive `rd_vld`=1 cycles, each returning the matching rk, with 1-cycle latency.
- **ld while busy:** `ld` pulses at t+4 and t+9 -> no extra `kld`, `done` only at t+13, captured keys unchanged.
- **Invalid reads:**
  - `rd_idx`=11 or 15 with `keys_vld`=1 -> `rd_vld`=0, `rd_key`=0.
  - Any `rd_idx` during EXP -> `rd_vld`=0.
- **Back-to-back restart:** second `ld` in the DONE cycle -> `kld` at t+14, `keys_vld` drops at t+14, second `done` at t+26 with the new key set.
